// File: rtl/pipe_mux_n.sv
// N:1 operand-select mux feeding a registered output stage backed by a one-beat
// skid register, so upstream ready is a flop and never waits on out_ready.
module pipe_mux_n #(
    parameter int N     = 3,
    parameter int W     = 32,
    parameter int SEL_W = 2,
    parameter int CNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [SEL_W-1:0]   sel,
    input  logic [N*W-1:0]     data_in,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [W-1:0]       data_out,
    output logic               sel_err,
    output logic [CNT_W-1:0]   err_cnt
);

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] TWO   = 2'd2;

    // Returns {err, data}; any select with no matching input yields zero data.
    function automatic logic [W:0] select_beat(input logic [SEL_W-1:0] s,
                                               input logic [N*W-1:0]   d);
        logic [W:0] r;
        r = {1'b1, {W{1'b0}}};
        for (int i = 0; i < N; i++) begin
            if (s == SEL_W'(i)) begin
                r = {1'b0, d[i*W +: W]};
            end
        end
        return r;
    endfunction

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + CNT_W'(1);
    endfunction

    logic [1:0]       state;
    logic             in_ready_r;
    logic [W-1:0]     main_data_p1;
    logic             main_err_p1;
    logic [W-1:0]     skid_data_p1;
    logic             skid_err_p1;
    logic [CNT_W-1:0] err_cnt_r;

    logic [W:0]       beat_p0;
    logic [W-1:0]     sel_data_p0;
    logic             sel_err_p0;
    logic             vld_p1;
    logic             accept;
    logic             deliver;

    // Stage p0: select evaluated at accept time.
    always_comb begin
        beat_p0     = select_beat(sel, data_in);
        sel_data_p0 = beat_p0[W-1:0];
        sel_err_p0  = beat_p0[W];
    end

    assign vld_p1  = (state != EMPTY);
    assign accept  = in_valid & in_ready_r;
    assign deliver = vld_p1 & out_ready;

    // Stage p1: main/skid registers and occupancy state.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= EMPTY;
            in_ready_r   <= 1'b1;
            main_data_p1 <= '0;
            main_err_p1  <= 1'b0;
            skid_data_p1 <= '0;
            skid_err_p1  <= 1'b0;
            err_cnt_r    <= '0;
        end else if (flush) begin
            // Held data is left in place; it is invisible once out_valid drops.
            state      <= EMPTY;
            in_ready_r <= 1'b1;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        main_data_p1 <= sel_data_p0;
                        main_err_p1  <= sel_err_p0;
                        state        <= ONE;
                    end
                end
                ONE: begin
                    if (accept && deliver) begin
                        main_data_p1 <= sel_data_p0;
                        main_err_p1  <= sel_err_p0;
                    end else if (accept) begin
                        skid_data_p1 <= sel_data_p0;
                        skid_err_p1  <= sel_err_p0;
                        state        <= TWO;
                        in_ready_r   <= 1'b0;
                    end else if (deliver) begin
                        state <= EMPTY;
                    end
                end
                TWO: begin
                    if (deliver) begin
                        main_data_p1 <= skid_data_p1;
                        main_err_p1  <= skid_err_p1;
                        state        <= ONE;
                        in_ready_r   <= 1'b1;
                    end
                end
                default: begin
                    state      <= EMPTY;
                    in_ready_r <= 1'b1;
                end
            endcase
            if (accept && sel_err_p0) begin
                err_cnt_r <= sat_inc(err_cnt_r);
            end
        end
    end

    assign in_ready  = in_ready_r;
    assign out_valid = vld_p1;
    assign data_out  = main_data_p1;
    assign sel_err   = main_err_p1;
    assign err_cnt   = err_cnt_r;

endmodule

// File: tb/tb_pipe_mux_n.sv
// Bench for pipe_mux_n: directed scenarios on a 3-input instance (twin with a
// 2-bit error counter) and a random run on a 5-input instance, scoreboard-checked.
module tb_pipe_mux_n;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n, flush;

    // Shared stimulus for instances a (CNT_W=8) and b (CNT_W=2)
    logic         in_valid, out_ready;
    logic [1:0]   sel;
    logic [95:0]  data_in;
    logic         in_ready_a, out_valid_a, sel_err_a;
    logic [31:0]  data_out_a;
    logic [7:0]   err_cnt_a;
    logic         in_ready_b, out_valid_b, sel_err_b;
    logic [31:0]  data_out_b;
    logic [1:0]   err_cnt_b;
    logic [31:0]  exp_data_a;
    logic         exp_err_a;

    // Random-run instance c (N=5, W=16, SEL_W=3)
    logic         in_valid_c, out_ready_c;
    logic [2:0]   sel_c;
    logic [79:0]  data_c;
    logic         in_ready_c, out_valid_c, sel_err_c;
    logic [15:0]  data_out_c;
    logic [7:0]   err_cnt_c;
    logic [15:0]  exp_data_c;
    logic         exp_err_c;
    int           model_err_c;

    int n_cmp  = 0;
    int n_fail = 0;

    logic [32:0] q_a[$];
    logic [16:0] q_c[$];

    pipe_mux_n #(.N(3), .W(32), .SEL_W(2), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready_a), .sel(sel), .data_in(data_in),
        .out_valid(out_valid_a), .out_ready(out_ready), .data_out(data_out_a),
        .sel_err(sel_err_a), .err_cnt(err_cnt_a));

    pipe_mux_n #(.N(3), .W(32), .SEL_W(2), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_ready(in_ready_b), .sel(sel), .data_in(data_in),
        .out_valid(out_valid_b), .out_ready(out_ready), .data_out(data_out_b),
        .sel_err(sel_err_b), .err_cnt(err_cnt_b));

    pipe_mux_n #(.N(5), .W(16), .SEL_W(3), .CNT_W(8)) dut_c (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid_c),
        .in_ready(in_ready_c), .sel(sel_c), .data_in(data_c),
        .out_valid(out_valid_c), .out_ready(out_ready_c), .data_out(data_out_c),
        .sel_err(sel_err_c), .err_cnt(err_cnt_c));

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor for a/b: deliveries are popped and compared, accepts push the
    // expected beat the driver announced alongside its stimulus.
    always @(negedge clk) begin
        if (!rst_n || flush) begin
            q_a.delete();
        end else begin
            if (out_valid_a && out_ready) begin
                if (q_a.size() == 0) begin
                    chk("a_unexpected_beat", 64'(data_out_a), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    logic [32:0] e;
                    e = q_a.pop_front();
                    chk("a_data", 64'(data_out_a), 64'(e[31:0]));
                    chk("a_sel_err", 64'(sel_err_a), 64'(e[32]));
                    chk("b_data", 64'({sel_err_b, data_out_b}), 64'(e));
                end
            end
            if (in_valid && in_ready_a) q_a.push_back({exp_err_a, exp_data_a});
        end
    end

    always @(negedge clk) begin
        if (!rst_n || flush) begin
            q_c.delete();
            if (!rst_n) model_err_c = 0;
        end else begin
            if (out_valid_c && out_ready_c) begin
                if (q_c.size() == 0) begin
                    chk("c_unexpected_beat", 64'(data_out_c), 64'hFFFF_FFFF_FFFF_FFFF);
                end else begin
                    logic [16:0] e;
                    e = q_c.pop_front();
                    chk("c_beat", 64'({sel_err_c, data_out_c}), 64'(e));
                end
            end
            if (in_valid_c && in_ready_c) begin
                q_c.push_back({exp_err_c, exp_data_c});
                if (exp_err_c && model_err_c < 255) model_err_c++;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] ins [3];
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        sel = '0; data_in = '0; exp_data_a = '0; exp_err_a = 1'b0;
        in_valid_c = 1'b0; out_ready_c = 1'b0; sel_c = '0; data_c = '0;
        exp_data_c = '0; exp_err_c = 1'b0; model_err_c = 0;

        // Reset for two cycles
        tick(); tick();
        chk("rst_out_valid", 64'(out_valid_a), 64'd0);
        chk("rst_in_ready", 64'(in_ready_a), 64'd1);
        chk("rst_err_cnt", 64'(err_cnt_a), 64'd0);
        chk("rst_data_out", 64'(data_out_a), 64'd0);
        rst_n = 1'b1;

        // Streaming, one-cycle latency
        out_ready = 1'b1;
        data_in = {32'h33, 32'h22, 32'h11};
        ins = '{32'h11, 32'h22, 32'h33};
        for (int k = 0; k < 3; k++) begin
            in_valid = 1'b1; sel = 2'(k); exp_data_a = ins[k]; exp_err_a = 1'b0;
            tick();
            chk("stream_valid", 64'(out_valid_a), 64'd1);
            chk("stream_data", 64'(data_out_a), 64'(ins[k]));
        end
        in_valid = 1'b0;
        tick();
        chk("stream_drained", 64'(out_valid_a), 64'd0);

        // Back-pressure: two beats fill main+skid, third waits
        out_ready = 1'b0;
        data_in = {32'hC3, 32'hB2, 32'hA1};
        in_valid = 1'b1; sel = 2'd0; exp_data_a = 32'hA1;
        tick();
        chk("bp_ready_one", 64'(in_ready_a), 64'd1);
        sel = 2'd1; exp_data_a = 32'hB2;
        tick();
        chk("bp_ready_two", 64'(in_ready_a), 64'd0);
        sel = 2'd2; exp_data_a = 32'hC3;
        tick();
        chk("bp_still_full", 64'(in_ready_a), 64'd0);
        chk("bp_hold_data", 64'(data_out_a), 64'hA1);
        out_ready = 1'b1;
        tick();
        chk("bp_second", 64'(data_out_a), 64'hB2);
        chk("bp_ready_back", 64'(in_ready_a), 64'd1);
        tick();
        chk("bp_third", 64'(data_out_a), 64'hC3);
        in_valid = 1'b0;
        tick();
        chk("bp_drained", 64'(out_valid_a), 64'd0);

        // Bad select and counter saturation
        data_in = {3{32'hDEADBEEF}};
        in_valid = 1'b1; sel = 2'd3; exp_data_a = 32'd0; exp_err_a = 1'b1;
        tick();
        chk("bad_data", 64'(data_out_a), 64'd0);
        chk("bad_flag", 64'(sel_err_a), 64'd1);
        chk("bad_cnt_a1", 64'(err_cnt_a), 64'd1);
        chk("bad_cnt_b1", 64'(err_cnt_b), 64'd1);
        repeat (4) tick();
        chk("bad_cnt_a5", 64'(err_cnt_a), 64'd5);
        chk("bad_cnt_b_sat", 64'(err_cnt_b), 64'd3);
        in_valid = 1'b0;
        tick();

        // Flush while TWO with a pending bad-select beat
        out_ready = 1'b0;
        data_in = {32'h77, 32'h66, 32'h55};
        in_valid = 1'b1; sel = 2'd0; exp_data_a = 32'h55; exp_err_a = 1'b0;
        tick();
        sel = 2'd3; exp_data_a = 32'd0; exp_err_a = 1'b1;
        tick();
        chk("fl_pre_cnt", 64'(err_cnt_a), 64'd6);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("fl_two_valid", 64'(out_valid_a), 64'd0);
        chk("fl_two_ready", 64'(in_ready_a), 64'd1);
        chk("fl_two_cnt", 64'(err_cnt_a), 64'd6);
        // Flush in ONE while a bad beat is accepted and the held one delivered
        sel = 2'd0; exp_data_a = 32'h55; exp_err_a = 1'b0;
        tick();
        sel = 2'd3; exp_data_a = 32'd0; exp_err_a = 1'b1;
        out_ready = 1'b1; flush = 1'b1;
        tick();
        flush = 1'b0; in_valid = 1'b0;
        chk("fl_one_valid", 64'(out_valid_a), 64'd0);
        chk("fl_one_cnt", 64'(err_cnt_a), 64'd6);
        for (int k = 0; k < 3; k++) begin
            tick();
            chk("fl_no_stale", 64'(out_valid_a), 64'd0);
        end

        // Reset while TWO
        out_ready = 1'b0;
        in_valid = 1'b1; sel = 2'd1; exp_data_a = 32'h66; exp_err_a = 1'b0;
        tick();
        sel = 2'd2; exp_data_a = 32'h77;
        tick();
        chk("rt_full", 64'(in_ready_a), 64'd0);
        in_valid = 1'b0; rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        chk("rt_valid", 64'(out_valid_a), 64'd0);
        chk("rt_ready", 64'(in_ready_a), 64'd1);
        chk("rt_cnt", 64'(err_cnt_a), 64'd0);
        chk("rt_data", 64'(data_out_a), 64'd0);

        // Random valid/ready/sel on the 5-input instance
        for (int cyc = 0; cyc < 800; cyc++) begin
            in_valid_c  = 1'($urandom_range(0, 1));
            out_ready_c = ($urandom_range(0, 3) != 0);
            sel_c       = 3'($urandom_range(0, 7));
            for (int l = 0; l < 5; l++) data_c[l*16 +: 16] = 16'($urandom);
            if (sel_c < 3'd5) begin
                exp_data_c = data_c[int'(sel_c)*16 +: 16];
                exp_err_c  = 1'b0;
            end else begin
                exp_data_c = 16'd0;
                exp_err_c  = 1'b1;
            end
            tick();
        end
        in_valid_c = 1'b0; out_ready_c = 1'b1;
        repeat (4) tick();
        chk("c_drained", 64'(out_valid_c), 64'd0);
        chk("c_queue_empty", 64'(q_c.size()), 64'd0);
        chk("c_err_cnt", 64'(err_cnt_c), 64'(model_err_c));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
